// File: rtl/demux_8bit_stream_pkg.sv
// Shared types and constants for the 1-to-2 stream demultiplexer.
package demux_8bit_stream_pkg;

    localparam int unsigned DEF_WIDTH = 8;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    typedef struct packed {
        logic                 w;
        logic [DEF_WIDTH-1:0] data;
    } entry_t;

endpackage

// File: rtl/demux_chan_fifo.sv
// Single-channel FIFO: DEPTH entries of {w, data}, valid/ready head, accepted-word counter.
module demux_chan_fifo
    import demux_8bit_stream_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             push_w,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head_data,
    output logic             head_w,
    output logic [CNT_W-1:0] cnt
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   occ_t;

    localparam occ_t OCC_FULL = occ_t'(DEPTH);

    logic [WIDTH:0] mem [DEPTH];
    ptr_t           wr_ptr;
    ptr_t           rd_ptr;
    occ_t           occ;
    logic           do_push;
    logic           do_pop;

    // full/empty come only from registered occupancy, so a same-cycle pop never frees room for a push
    assign full    = (occ == OCC_FULL);
    assign empty   = (occ == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    assign head_data = mem[rd_ptr][WIDTH-1:0];
    assign head_w    = mem[rd_ptr][WIDTH];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            cnt    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= {push_w, push_data};
                wr_ptr      <= wr_ptr + ptr_t'(1);
                cnt         <= cnt + CNT_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + ptr_t'(1);
            end
            case ({do_push, do_pop})
                2'b10:   occ <= occ + occ_t'(1);
                2'b01:   occ <= occ - occ_t'(1);
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/demux_8bit_stream.sv
// Steers each accepted {w, data} word into one of two independent channel FIFOs by in_sel.
module demux_8bit_stream
    import demux_8bit_stream_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_w,
    input  logic             in_sel,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_w,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_w,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    logic full0;
    logic full1;
    logic empty0;
    logic empty1;
    logic push0;
    logic push1;

    // ready follows the selected channel only, so a stalled channel never blocks the other
    assign in_ready = (in_sel == CH0) ? ~full0 : ~full1;
    assign push0    = in_valid & in_ready & (in_sel == CH0);
    assign push1    = in_valid & in_ready & (in_sel == CH1);

    assign out0_valid = ~empty0;
    assign out1_valid = ~empty1;

    demux_chan_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) u_chan0 (
        .clock     (clock),
        .reset     (reset),
        .push      (push0),
        .push_data (in_data),
        .push_w    (in_w),
        .pop       (out0_ready),
        .full      (full0),
        .empty     (empty0),
        .head_data (out0_data),
        .head_w    (out0_w),
        .cnt       (cnt0)
    );

    demux_chan_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) u_chan1 (
        .clock     (clock),
        .reset     (reset),
        .push      (push1),
        .push_data (in_data),
        .push_w    (in_w),
        .pop       (out1_ready),
        .full      (full1),
        .empty     (empty1),
        .head_data (out1_data),
        .head_w    (out1_w),
        .cnt       (cnt1)
    );

endmodule

// File: tb/tb_demux_8bit_stream.sv
// Directed and scoreboard-checked bench for demux_8bit_stream.
module tb_demux_8bit_stream;
    import demux_8bit_stream_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_w;
    logic       in_sel;
    logic       out0_valid;
    logic       out0_ready;
    logic [7:0] out0_data;
    logic       out0_w;
    logic       out1_valid;
    logic       out1_ready;
    logic [7:0] out1_data;
    logic       out1_w;
    logic [7:0] cnt0;
    logic [7:0] cnt1;

    int total = 0;
    int bad   = 0;

    demux_8bit_stream #(.WIDTH(8), .DEPTH(2), .CNT_W(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_w       (in_w),
        .in_sel     (in_sel),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out0_w     (out0_w),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .out1_w     (out1_w),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid   = 1'b0;
        in_data    = 8'h00;
        in_w       = 1'b0;
        in_sel     = 1'b0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        step();
        total++; if (in_ready !== 1'b1)   begin bad++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        total++; if (out0_valid !== 1'b0) begin bad++; $display("FAIL reset_out0_valid: got %0b want 0", out0_valid); end
        total++; if (out1_valid !== 1'b0) begin bad++; $display("FAIL reset_out1_valid: got %0b want 0", out1_valid); end
        total++; if (cnt0 !== 8'd0 || cnt1 !== 8'd0) begin bad++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", cnt0, cnt1); end
        total++; if ({out0_w, out0_data, out1_w, out1_data} !== 18'd0) begin bad++;
            $display("FAIL reset_data: got %0h/%0h want 0/0", out0_data, out1_data); end
    endtask

    task automatic test_single_push();
        in_valid = 1'b1; in_sel = CH0; in_data = 8'hA5; in_w = 1'b1;
        step();
        in_valid = 1'b0;
        total++; if (out0_valid !== 1'b1) begin bad++; $display("FAIL single_valid: got %0b want 1", out0_valid); end
        total++; if (out0_data !== 8'hA5) begin bad++; $display("FAIL single_data: got %0h want a5", out0_data); end
        total++; if (out0_w !== 1'b1)     begin bad++; $display("FAIL single_w: got %0b want 1", out0_w); end
        total++; if (out1_valid !== 1'b0) begin bad++; $display("FAIL single_out1_valid: got %0b want 0", out1_valid); end
        total++; if (cnt0 !== 8'd1)       begin bad++; $display("FAIL single_cnt0: got %0d want 1", cnt0); end
        step();
        total++; if (out0_data !== 8'hA5) begin bad++; $display("FAIL single_hold: got %0h want a5", out0_data); end
        out0_ready = 1'b1;
        step();
        out0_ready = 1'b0;
        total++; if (out0_valid !== 1'b0) begin bad++; $display("FAIL single_drain: got %0b want 0", out0_valid); end
    endtask

    task automatic test_full_redirect();
        do_reset();
        in_valid = 1'b1; in_sel = CH1; in_w = 1'b0; in_data = 8'h11;
        step();
        in_data = 8'h22;
        step();
        in_data = 8'h33;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_ready: got %0b want 0", in_ready); end
        step();
        total++; if (cnt1 !== 8'd2)       begin bad++; $display("FAIL full_cnt1: got %0d want 2", cnt1); end
        total++; if (out1_data !== 8'h11) begin bad++; $display("FAIL full_head: got %0h want 11", out1_data); end
        in_sel = CH0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL redirect_ready: got %0b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        total++; if (out0_valid !== 1'b1 || out0_data !== 8'h33) begin bad++;
            $display("FAIL redirect_ch0: got v=%0b d=%0h want v=1 d=33", out0_valid, out0_data); end
        total++; if (cnt0 !== 8'd1 || cnt1 !== 8'd2) begin bad++;
            $display("FAIL redirect_cnt: got %0d/%0d want 1/2", cnt0, cnt1); end
        out0_ready = 1'b1;
        step();
        out0_ready = 1'b0;
    endtask

    task automatic test_pop_push_same();
        // ch1 still holds 0x11, 0x22 from the previous task
        in_valid = 1'b1; in_sel = CH1; in_data = 8'h44; in_w = 1'b1; out1_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL popush_ready: got %0b want 0", in_ready); end
        step();
        out1_ready = 1'b0;
        total++; if (out1_data !== 8'h22 || cnt1 !== 8'd2) begin bad++;
            $display("FAIL popush_pop: got d=%0h cnt=%0d want d=22 cnt=2", out1_data, cnt1); end
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL popush_ready2: got %0b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        total++; if (cnt1 !== 8'd3 || out1_data !== 8'h22) begin bad++;
            $display("FAIL popush_push: got d=%0h cnt=%0d want d=22 cnt=3", out1_data, cnt1); end
        out1_ready = 1'b1;
        step();
        total++; if (out1_valid !== 1'b1 || out1_data !== 8'h44 || out1_w !== 1'b1) begin bad++;
            $display("FAIL popush_order: got v=%0b d=%0h w=%0b want v=1 d=44 w=1", out1_valid, out1_data, out1_w); end
        step();
        out1_ready = 1'b0;
        total++; if (out1_valid !== 1'b0) begin bad++; $display("FAIL popush_empty: got %0b want 0", out1_valid); end
    endtask

    task automatic test_stream();
        logic [7:0] exp;
        do_reset();
        out0_ready = 1'b1; in_sel = CH0; in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            exp     = 8'(i);
            in_data = exp;
            in_w    = exp[0];
            step();
            total++;
            if (out0_valid !== 1'b1 || out0_data !== exp || out0_w !== exp[0]) begin bad++;
                $display("FAIL stream_word%0d: got v=%0b d=%0h want v=1 d=%0h", i, out0_valid, out0_data, exp); end
        end
        in_valid = 1'b0;
        step();
        total++; if (out0_valid !== 1'b0) begin bad++; $display("FAIL stream_drained: got %0b want 0", out0_valid); end
        total++; if (cnt0 !== 8'd44 || cnt1 !== 8'd0) begin bad++;
            $display("FAIL stream_cnt: got %0d/%0d want 44/0", cnt0, cnt1); end
        out0_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        in_valid = 1'b1; in_sel = CH0; in_data = 8'h55; in_w = 1'b1;
        step();
        in_data = 8'h66;
        step();
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        total++; if (out0_valid !== 1'b0 || out0_data !== 8'h00 || out0_w !== 1'b0) begin bad++;
            $display("FAIL midrst_out: got v=%0b d=%0h want v=0 d=0", out0_valid, out0_data); end
        total++; if (cnt0 !== 8'd0 || in_ready !== 1'b1) begin bad++;
            $display("FAIL midrst_state: got cnt=%0d rdy=%0b want cnt=0 rdy=1", cnt0, in_ready); end
        step();
        reset = 1'b0;
        out0_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            total++; if (out0_valid !== 1'b0) begin bad++; $display("FAIL midrst_emit: got %0b want 0", out0_valid); end
        end
        out0_ready = 1'b0;
    endtask

    task automatic test_random();
        entry_t q0[$];
        entry_t q1[$];
        entry_t got;
        int     n0 = 0;
        int     n1 = 0;
        logic   exp_rdy;
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            in_valid   = 1'($urandom_range(0, 1));
            in_sel     = 1'($urandom_range(0, 1));
            in_data    = 8'($urandom);
            in_w       = 1'($urandom_range(0, 1));
            out0_ready = ($urandom_range(0, 3) == 0);
            out1_ready = ($urandom_range(0, 2) != 0);
            #1;
            exp_rdy = in_sel ? (q1.size() < 2) : (q0.size() < 2);
            total++; if (in_ready !== exp_rdy) begin bad++;
                $display("FAIL rnd_ready c=%0d: got %0b want %0b", c, in_ready, exp_rdy); end
            total++; if (out0_valid !== (q0.size() != 0) || out1_valid !== (q1.size() != 0)) begin bad++;
                $display("FAIL rnd_valid c=%0d: got %0b%0b want %0b%0b", c, out0_valid, out1_valid,
                         q0.size() != 0, q1.size() != 0); end
            if (q0.size() != 0) begin
                got = '{w: out0_w, data: out0_data};
                total++; if (got !== q0[0]) begin bad++;
                    $display("FAIL rnd_head0 c=%0d: got %0h want %0h", c, got, q0[0]); end
            end
            if (q1.size() != 0) begin
                got = '{w: out1_w, data: out1_data};
                total++; if (got !== q1[0]) begin bad++;
                    $display("FAIL rnd_head1 c=%0d: got %0h want %0h", c, got, q1[0]); end
            end
            if (out0_ready && q0.size() != 0) void'(q0.pop_front());
            if (out1_ready && q1.size() != 0) void'(q1.pop_front());
            if (in_valid && exp_rdy) begin
                if (in_sel) begin q1.push_back('{w: in_w, data: in_data}); n1++; end
                else        begin q0.push_back('{w: in_w, data: in_data}); n0++; end
            end
            step();
        end
        total++; if (cnt0 !== 8'(n0) || cnt1 !== 8'(n1)) begin bad++;
            $display("FAIL rnd_cnt: got %0d/%0d want %0d/%0d", cnt0, cnt1, 8'(n0), 8'(n1)); end
        idle_inputs();
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        test_reset();
        test_single_push();
        test_full_redirect();
        test_pop_push_same();
        test_stream();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/demux_8bit_stream.md
Name: demux_8bit_stream

Overview:
- Sequential 1-to-2 steering block: takes one 8-bit data word plus a 1-bit side bit (carry/flag) and delivers it to one of two sink channels chosen by a select bit.
- Each channel has its own small FIFO and a valid/ready handshake.
- Fans ALU/adder slice results out to two consumers, such as a writeback path and a status/flag path.
- Every accepted word reaches exactly one sink. No word is dropped or duplicated, and order is preserved within each channel.

Parameters:
- WIDTH, 8, data word width in bits
- DEPTH, 2, entries per channel FIFO; must be a power of 2 and at least 2
- CNT_W, 8, width of the per-channel accepted-word counters

Ports:
- clock  input  1  single clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- in_valid  input  1  source presents a word this cycle
- in_ready  output  1  block accepts the word this cycle
- in_data  input  WIDTH  data word
- in_w  input  1  side bit travelling with the word
- in_sel  input  1  destination: 0 routes to channel 0, 1 routes to channel 1
- out0_valid  output  1  channel 0 head entry valid
- out0_ready  input  1  channel 0 sink takes the head entry
- out0_data  output  WIDTH  channel 0 head data
- out0_w  output  1  channel 0 head side bit
- out1_valid, out1_ready, out1_data, out1_w  same meanings as the channel 0 ports, for channel 1
- cnt0  output  CNT_W  words accepted into channel 0 since reset
- cnt1  output  CNT_W  words accepted into channel 1 since reset

Behaviour:
- Reset (async, high):
  - All FIFO read/write pointers and occupancy cleared.
  - out0_valid = out1_valid = 0.
  - out*_data = 0, out*_w = 0.
  - cnt0 = cnt1 = 0.
  - in_ready = 1 (both channels empty).
  - Asserting reset mid-transfer discards all buffered words. There is no partial state after reset release.
- Ready rule:
  - in_ready = ~full0 when in_sel = 0, and ~full1 when in_sel = 1.
  - full is derived from registered occupancy only. A same-cycle pop does not free space for a same-cycle push (no combinational ready-to-ready path).
  - in_ready may change combinationally with in_sel.
- Push:
  - On a rising edge with in_valid & in_ready, {in_w, in_data} is written at the selected channel's write pointer.
  - That write pointer advances modulo DEPTH.
  - That channel's occupancy increments.
  - That channel's cnt increments and wraps from 2^CNT_W-1 to 0.
- Pop:
  - On a rising edge with outN_valid & outN_ready, channel N's read pointer advances modulo DEPTH and occupancy decrements.
  - outN_ready while outN_valid = 0 has no effect (no underflow).
- Simultaneous push and pop on the same non-full channel: occupancy unchanged, both pointers advance.
  - A non-empty channel presents its old head this cycle. The pushed word appears later, in order.
- Latency: a word accepted at edge k is visible on outN_valid/data/w after edge k if that channel was empty. outN_* always reflect the head entry from registered state only.
- Output stability: while outN_valid = 1 and outN_ready = 0, outN_data and outN_w hold steady.
- Channel independence: a full or stalled channel never blocks the other channel.
- Empty channel: outN_data/outN_w show the stale head slot contents. Sinks qualify these with valid.

Decomposition:
- Shared package holds:
  - WIDTH default
  - the entry struct {w, data}
  - constants CH0 = 1'b0 and CH1 = 1'b1
- One natural sub-module, demux_chan_fifo: a single-channel DEPTH-entry FIFO with push/pop, full/empty, and an accepted counter.
  - The top instantiates it twice plus the select/ready steering logic.

Test Plan:
- Reset then idle -> in_ready = 1, out0_valid = out1_valid = 0, cnt0 = cnt1 = 0; assert reset mid-stream with 2 words buffered -> outputs clear the same cycle, no word emitted after release.
- Push 0xA5 with w = 1, sel = 0, out0_ready = 0 -> after one edge out0_valid = 1, out0_data = 0xA5, out0_w = 1, out1_valid = 0, cnt0 = 1.
- Push 0x11, 0x22 to ch1 with out1_ready = 0, then offer 0x33 to ch1 -> in_ready = 0 and 0x33 is not taken; switch sel = 0 -> in_ready = 1 and 0x33 lands in ch0.
- Ch1 full; in the same cycle assert out1_ready = 1 and offer a ch1 push -> push refused (in_ready = 0), pop of 0x11 happens; next cycle push accepted; ch1 drain order is 0x22 then the new word.
- Stream 300 words to ch0 with out0_ready = 1 every cycle -> all delivered in order, cnt0 wraps to 300 - 256 = 44 (CNT_W = 8), cnt1 = 0.
- Random sel/valid/ready for 10k cycles against a scoreboard of two reference queues -> no loss, duplication, or reordering per channel, and outputs hold steady under backpressure.
